// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand selector with EX/MEM and MEM/WB forwarding.
// Defining LOAD_USE_DETECT_EN enables load-use hazard detection and automatic bubble insertion.
module ex_operand_stage #(
  parameter int         DW        = 16,
  parameter int         RW        = 4,
  parameter logic [3:0] BUBBLE_OP = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_wr_en,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [DW-1:0] id_pc_next,
  input  logic          exmem_wr_en,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_wr_en,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [3:0]    ex_opcode,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_wr_en,
  output logic          load_use_stall
);

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_PCS = 4'b1110;

  logic          valid_q;
  logic [3:0]    opcode_q;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  logic          wr_en_q;
  logic [DW-1:0] rs_data_q, rt_data_q, imm_q, pc_next_q;
  logic          use_imm_q;

  logic [DW-1:0] fwd_rs, fwd_rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      opcode_q  <= BUBBLE_OP;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      pc_next_q <= '0;
    end else if (flush || (!stall && (!id_valid || load_use_stall))) begin
      valid_q   <= 1'b0;
      opcode_q  <= BUBBLE_OP;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      pc_next_q <= '0;
    end else if (!stall) begin
      valid_q   <= 1'b1;
      opcode_q  <= id_opcode;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      wr_en_q   <= id_wr_en;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      use_imm_q <= id_use_imm;
      pc_next_q <= id_pc_next;
    end
  end

  // The youngest in-flight producer wins; R0 is hardwired to zero regardless of writers.
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] rf);
    if (src == '0)                          return '0;
    else if (exmem_wr_en && exmem_rd == src) return exmem_result;
    else if (memwb_wr_en && memwb_rd == src) return memwb_result;
    else                                     return rf;
  endfunction

  always_comb begin
    fwd_rs        = fwd(rs_q, rs_data_q);
    fwd_rt        = fwd(rt_q, rt_data_q);
    ex_valid      = valid_q;
    ex_opcode     = valid_q ? opcode_q : BUBBLE_OP;
    ex_rd         = rd_q;
    ex_wr_en      = valid_q & wr_en_q;
    ex_store_data = fwd_rt;
    alu_in1       = '0;
    alu_in2       = '0;
    if (valid_q) begin
      alu_in1 = (opcode_q == OP_PCS) ? pc_next_q : fwd_rs;
      alu_in2 = use_imm_q ? imm_q : fwd_rt;
    end
  end

`ifdef LOAD_USE_DETECT_EN
  // SW reads rt as store data even though Input2 carries the immediate.
  assign load_use_stall = ex_valid && (ex_opcode == OP_LW) && ex_wr_en && (ex_rd != '0) &&
                          id_valid && ((ex_rd == id_rs) ||
                                       (!id_use_imm && ex_rd == id_rt) ||
                                       (id_opcode == OP_SW && ex_rd == id_rt));
`else
  assign load_use_stall = 1'b0;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed test of ex_operand_stage: reset, forwarding priority, R0, load-use, stall/flush, PCS.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, id_wr_en, id_use_imm;
  logic [3:0]  id_opcode, id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc_next, exmem_result, memwb_result;
  logic        exmem_wr_en, memwb_wr_en;
  logic        ex_valid, ex_wr_en, load_use_stall;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] alu_in1, alu_in2, ex_store_data;

  int n_chk = 0;
  int n_fail = 0;

`ifdef LOAD_USE_DETECT_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_pc_next(id_pc_next),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .load_use_stall(load_use_stall)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_drive(input logic v, input logic [3:0] op, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [3:0] rd, input logic we,
                          input logic [15:0] rsd, input logic [15:0] rtd,
                          input logic [15:0] imm, input logic ui, input logic [15:0] pcn);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; id_wr_en = we;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui; id_pc_next = pcn;
  endtask

  task automatic fwd_drive(input logic ew, input logic [3:0] er, input logic [15:0] eres,
                           input logic mw, input logic [3:0] mr, input logic [15:0] mres);
    exmem_wr_en = ew; exmem_rd = er; exmem_result = eres;
    memwb_wr_en = mw; memwb_rd = mr; memwb_result = mres;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_drive(0, 4'h0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
    fwd_drive(0, 0, 16'h0, 0, 0, 16'h0);
    #2;
    check("rst_valid", 16'(ex_valid), 16'h0);
    check("rst_opcode", 16'(ex_opcode), 16'hF);
    check("rst_wr_en", 16'(ex_wr_en), 16'h0);
    check("rst_rd", 16'(ex_rd), 16'h0);
    check("rst_in1", alu_in1, 16'h0);
    rst = 1'b0;

    // ADD R3,R1,R2: EX/MEM beats MEM/WB, then MEM/WB, then register file
    id_drive(1, 4'h0, 1, 2, 3, 1, 16'h1111, 16'h2222, 16'h0, 0, 16'h0);
    step();
    fwd_drive(1, 1, 16'h0005, 1, 1, 16'h0009);
    #1;
    check("add_valid", 16'(ex_valid), 16'h1);
    check("add_opcode", 16'(ex_opcode), 16'h0);
    check("add_rd", 16'(ex_rd), 16'h3);
    check("add_wr_en", 16'(ex_wr_en), 16'h1);
    check("add_in1_exmem", alu_in1, 16'h0005);
    check("add_in2_rf", alu_in2, 16'h2222);
    exmem_wr_en = 1'b0; #1;
    check("add_in1_memwb", alu_in1, 16'h0009);
    memwb_wr_en = 1'b0; #1;
    check("add_in1_rf", alu_in1, 16'h1111);

    // SUB R6,R0,R2: R0 ignores a matching EX/MEM write; rt from MEM/WB
    id_drive(1, 4'h1, 0, 2, 6, 1, 16'hAAAA, 16'h0003, 16'h0, 0, 16'h0);
    step();
    fwd_drive(1, 0, 16'h1234, 1, 2, 16'h7777);
    #1;
    check("sub_in1_r0", alu_in1, 16'h0000);
    check("sub_in2_memwb", alu_in2, 16'h7777);
    check("sub_store", ex_store_data, 16'h7777);

    // LW R4,16(R1), then ADD R5,R4,R4 in decode
    fwd_drive(0, 0, 16'h0, 0, 0, 16'h0);
    id_drive(1, 4'h8, 1, 4, 4, 1, 16'h0100, 16'h0, 16'h0010, 1, 16'h0);
    step();
    check("lw_in1", alu_in1, 16'h0100);
    check("lw_in2_imm", alu_in2, 16'h0010);
    id_drive(1, 4'h0, 1, 4, 7, 1, 16'h0100, 16'hDEAD, 16'h0005, 1, 16'h0);
    #1;
    check("lu_imm_rt_no_hazard", 16'(load_use_stall), 16'h0);
    id_drive(1, 4'h9, 1, 4, 0, 0, 16'h0100, 16'hDEAD, 16'h0002, 1, 16'h0);
    #1;
    check("lu_sw_rt", 16'(load_use_stall), 16'(LU));
    id_drive(1, 4'h0, 4, 4, 5, 1, 16'hDEAD, 16'hDEAD, 16'h0, 0, 16'h0);
    #1;
    check("lu_add", 16'(load_use_stall), 16'(LU));
    step();
    if (LU) begin
      check("lu_bubble_valid", 16'(ex_valid), 16'h0);
      check("lu_bubble_opcode", 16'(ex_opcode), 16'hF);
      check("lu_bubble_wr_en", 16'(ex_wr_en), 16'h0);
      check("lu_released", 16'(load_use_stall), 16'h0);
      step();
    end
    fwd_drive(0, 0, 16'h0, 1, 4, 16'h4444);
    #1;
    check("lu_add_valid", 16'(ex_valid), 16'h1);
    check("lu_add_rd", 16'(ex_rd), 16'h5);
    check("lu_add_in1", alu_in1, 16'h4444);
    check("lu_add_in2", alu_in2, 16'h4444);

    // PCS R15 with pc_next 0x0042
    fwd_drive(0, 0, 16'h0, 0, 0, 16'h0);
    id_drive(1, 4'hE, 7, 0, 15, 1, 16'h5555, 16'h0, 16'h0, 0, 16'h0042);
    step();
    check("pcs_in1", alu_in1, 16'h0042);
    check("pcs_opcode", 16'(ex_opcode), 16'hE);
    check("pcs_wr_en", 16'(ex_wr_en), 16'h1);

    // Three stalled cycles with changing decode fields
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_drive(1, 4'(i + 2), 4'(i + 1), 4'(i + 2), 4'(i + 3), 1, 16'(i + 16'h30),
               16'h0, 16'h0, 0, 16'(i + 16'h90));
      step();
      check("stall_opcode", 16'(ex_opcode), 16'hE);
      check("stall_in1", alu_in1, 16'h0042);
      check("stall_rd", 16'(ex_rd), 16'hF);
    end
    flush = 1'b1;
    step();
    check("flush_valid", 16'(ex_valid), 16'h0);
    check("flush_opcode", 16'(ex_opcode), 16'hF);
    check("flush_wr_en", 16'(ex_wr_en), 16'h0);
    check("flush_in1", alu_in1, 16'h0);
    flush = 1'b0; stall = 1'b0;

    // Invalid decode slot loads a bubble
    id_drive(0, 4'h0, 1, 2, 3, 1, 16'h1111, 16'h2222, 16'h0, 0, 16'h0);
    step();
    check("idinv_valid", 16'(ex_valid), 16'h0);
    check("idinv_wr_en", 16'(ex_wr_en), 16'h0);

    // Asynchronous reset mid-cycle
    id_drive(1, 4'h2, 1, 2, 9, 1, 16'h00AB, 16'h00CD, 16'h0, 0, 16'h0);
    step();
    check("pre_rst_valid", 16'(ex_valid), 16'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 16'(ex_valid), 16'h0);
    check("async_rst_opcode", 16'(ex_opcode), 16'hF);
    check("async_rst_wr_en", 16'(ex_wr_en), 16'h0);
    check("async_rst_in1", alu_in1, 16'h0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
